// File: rtl/banner_pkg.sv
// Shared types and geometry for the "PRESS START" title banner.
package banner_pkg;

  typedef enum logic [2:0] {
    HIDDEN    = 3'd0,
    ON        = 3'd1,
    OFF       = 3'd2,
    FLASH_ON  = 3'd3,
    FLASH_OFF = 3'd4,
    DONE      = 3'd5
  } banner_state_t;

  localparam int BANNER_W = 110;
  localparam int BANNER_H = 16;

endpackage

// File: rtl/frame_edge.sv
// Registered single-cycle edge detector; falling edge for vsync, rising edge for the button.
module frame_edge #(
  parameter logic RST_VAL = 1'b1,
  parameter bit   RISING  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic prev;

  // Delay the input one clock and register the selected edge as a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= RST_VAL;
      pulse <= 1'b0;
    end else begin
      prev  <= din;
      pulse <= RISING ? (~prev & din) : (prev & ~din);
    end
  end

endmodule

// File: rtl/pstart_banner.sv
// Title banner renderer: two-stage coordinate-to-pixel pipeline plus blink/flash sequencer.
module pstart_banner
  import banner_pkg::*;
#(
  parameter logic [9:0] X0           = 10'd265,
  parameter logic [9:0] Y0           = 10'd300,
  parameter int         BLINK_FRAMES = 30,
  parameter int         FLASH_FRAMES = 4,
  parameter int         FLASH_COUNT  = 6
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic         VS,
  input  logic         enable,
  input  logic         start_btn,
  output logic [3:0]   rom_addr,
  input  logic [109:0] rom_data,
  output logic         pixel_on,
  output logic         start_done
);

  banner_state_t state, state_next;
  logic [5:0]    frame_cnt;
  logic [2:0]    flash_cnt, flash_next;
  logic          frame_tick, btn_edge;
  logic          visible, blink_end, flash_end;
  logic [9:0]    dx, dy;
  logic          in_box_q;
  logic [6:0]    col, bit_idx;
  logic [127:0]  rom_ext;

  frame_edge #(.RST_VAL(1'b1), .RISING(1'b0)) u_vs_edge (
    .clk(Clk), .rst_n(Reset_n), .din(VS), .pulse(frame_tick)
  );

  frame_edge #(.RST_VAL(1'b0), .RISING(1'b1)) u_btn_edge (
    .clk(Clk), .rst_n(Reset_n), .din(start_btn), .pulse(btn_edge)
  );

  // Unsigned wrap makes anything left of / above the box fail the range compare.
  assign dx      = DrawX - X0;
  assign dy      = DrawY - Y0;
  assign bit_idx = 7'd109 - col;
  assign rom_ext = {18'd0, rom_data};
  assign visible = (state == ON) || (state == FLASH_ON);

  assign blink_end = frame_tick && (frame_cnt == 6'(BLINK_FRAMES - 1));
  assign flash_end = frame_tick && (frame_cnt == 6'(FLASH_FRAMES - 1));

  // Stage 1 registers the box test and ROM address; stage 2 selects the bit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_box_q <= 1'b0;
      rom_addr <= 4'd0;
      col      <= 7'd0;
      pixel_on <= 1'b0;
    end else begin
      in_box_q <= (dx < 10'(BANNER_W)) && (dy < 10'(BANNER_H));
      rom_addr <= dy[3:0];
      col      <= dx[6:0];
      pixel_on <= in_box_q && visible && rom_ext[bit_idx];
    end
  end

  // Next-state logic; a button edge outranks a blink period end.
  always_comb begin
    state_next = state;
    flash_next = flash_cnt;
    if (!enable) begin
      state_next = HIDDEN;
    end else begin
      case (state)
        HIDDEN: state_next = ON;
        ON: begin
          if (btn_edge) begin
            state_next = FLASH_ON;
            flash_next = 3'd0;
          end else if (blink_end) begin
            state_next = OFF;
          end else begin
            state_next = ON;
          end
        end
        OFF: begin
          if (btn_edge) begin
            state_next = FLASH_ON;
            flash_next = 3'd0;
          end else if (blink_end) begin
            state_next = ON;
          end else begin
            state_next = OFF;
          end
        end
        FLASH_ON: begin
          if (flash_end) begin
            state_next = FLASH_OFF;
          end else begin
            state_next = FLASH_ON;
          end
        end
        FLASH_OFF: begin
          if (flash_end && (flash_cnt == 3'(FLASH_COUNT - 1))) begin
            state_next = DONE;
          end else if (flash_end) begin
            state_next = FLASH_ON;
            flash_next = flash_cnt + 3'd1;
          end else begin
            state_next = FLASH_OFF;
          end
        end
        DONE:    state_next = DONE;
        default: state_next = HIDDEN;
      endcase
    end
  end

  // State, counters and the DONE-entry pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= HIDDEN;
      frame_cnt  <= 6'd0;
      flash_cnt  <= 3'd0;
      start_done <= 1'b0;
    end else begin
      state      <= state_next;
      flash_cnt  <= flash_next;
      start_done <= (state_next == DONE) && (state != DONE);
      if (state_next != state) begin
        frame_cnt <= 6'd0;
      end else if (frame_tick) begin
        frame_cnt <= frame_cnt + 6'd1;
      end else begin
        frame_cnt <= frame_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pstart_banner.sv
// Directed bench for pstart_banner with a behavioural start-text ROM.
module tb_pstart_banner;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [9:0]   DrawX = 10'd264;
  logic [9:0]   DrawY = 10'd300;
  logic         VS = 1'b1;
  logic         enable = 1'b0;
  logic         start_btn = 1'b0;
  logic [3:0]   rom_addr;
  logic [109:0] rom_data;
  logic         pixel_on;
  logic         start_done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  pstart_banner dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .VS(VS),
    .enable(enable), .start_btn(start_btn), .rom_addr(rom_addr),
    .rom_data(rom_data), .pixel_on(pixel_on), .start_done(start_done)
  );

  always #5 Clk = ~Clk;

  // All rows fully lit except row 2, which has bit 103 dark.
  always_comb begin
    rom_data = {110{1'b1}};
    if (rom_addr == 4'd2) rom_data[103] = 1'b0;
  end

  always @(negedge Clk) if (start_done === 1'b1) done_cnt = done_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic exp_pix, input logic [3:0] exp_addr);
    DrawX = x;
    DrawY = y;
    repeat (2) @(negedge Clk);
    chk({tag, "_pix"}, 16'(pixel_on), 16'(exp_pix));
    chk({tag, "_addr"}, 16'(rom_addr), 16'(exp_addr));
  endtask

  task automatic tick();
    VS = 1'b0;
    repeat (3) @(negedge Clk);
    VS = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_pix", 16'(pixel_on), 16'd0);
    chk("rst_addr", 16'(rom_addr), 16'd0);
    chk("rst_done", 16'(start_done), 16'd0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    pix("hidden", 10'd265, 10'd302, 1'b0, 4'd2);

    enable = 1'b1;
    DrawX = 10'd264;
    DrawY = 10'd300;
    repeat (3) @(negedge Clk);
    DrawX = 10'd265;
    DrawY = 10'd302;
    @(negedge Clk);
    chk("lat1_pix", 16'(pixel_on), 16'd0);
    chk("lat1_addr", 16'(rom_addr), 16'd2);
    @(negedge Clk);
    chk("lat2_pix", 16'(pixel_on), 16'd1);
    pix("x271", 10'd271, 10'd302, 1'b0, 4'd2);
    pix("x266", 10'd266, 10'd302, 1'b1, 4'd2);
    pix("x264", 10'd264, 10'd302, 1'b0, 4'd2);
    pix("x374", 10'd374, 10'd302, 1'b1, 4'd2);
    pix("x375", 10'd375, 10'd302, 1'b0, 4'd2);
    pix("y315", 10'd300, 10'd315, 1'b1, 4'd15);
    pix("y316", 10'd300, 10'd316, 1'b0, 4'd0);
    pix("y299", 10'd300, 10'd299, 1'b0, 4'd15);
    pix("home", 10'd265, 10'd302, 1'b1, 4'd2);

    for (int i = 1; i <= 60; i++) begin
      tick();
      chk($sformatf("blink_t%0d", i), 16'(pixel_on), 16'((i < 30 || i >= 60) ? 1 : 0));
    end

    for (int i = 1; i <= 10; i++) tick();
    start_btn = 1'b1;
    repeat (4) @(negedge Clk);
    chk("press_pix", 16'(pixel_on), 16'd1);
    for (int j = 1; j <= 48; j++) begin
      tick();
      chk($sformatf("flash_t%0d", j), 16'(pixel_on),
          16'((j == 48) ? 0 : (((j / 4) % 2 == 0) ? 1 : 0)));
      chk($sformatf("done_t%0d", j), 16'(done_cnt), 16'((j == 48) ? 1 : 0));
    end
    start_btn = 1'b0;
    repeat (3) @(negedge Clk);
    start_btn = 1'b1;
    tick();
    chk("done_hold_pix", 16'(pixel_on), 16'd0);
    chk("done_once", 16'(done_cnt), 16'd1);
    start_btn = 1'b0;

    enable = 1'b0;
    repeat (3) @(negedge Clk);
    chk("dis_pix", 16'(pixel_on), 16'd0);
    enable = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reen_pix", 16'(pixel_on), 16'd1);
    for (int i = 1; i <= 29; i++) tick();
    chk("pre30_pix", 16'(pixel_on), 16'd1);
    VS = 1'b0;
    start_btn = 1'b1;
    repeat (3) @(negedge Clk);
    VS = 1'b1;
    repeat (4) @(negedge Clk);
    chk("tie_pix", 16'(pixel_on), 16'd1);
    for (int i = 1; i <= 4; i++) tick();
    chk("tie_foff_pix", 16'(pixel_on), 16'd0);

    #2 Reset_n = 1'b0;
    start_btn = 1'b0;
    #1;
    chk("arst_pix", 16'(pixel_on), 16'd0);
    chk("arst_addr", 16'(rom_addr), 16'd0);
    chk("arst_done", 16'(start_done), 16'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("post_rst_pix", 16'(pixel_on), 16'd1);
    for (int i = 1; i <= 48; i++) tick();
    chk("no_done_after_rst", 16'(done_cnt), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pstart_banner.md
# pstart_banner

Title-screen renderer for the "PRESS START" bitmap. Sits directly downstream of the 16×110 start-text ROM and beside the VGA controller. It maps the current VGA pixel coordinate into a ROM row address and a bit index, and registers the selected bit as a pixel-on flag for the colour mapper. It also blinks the text once per frame-counted period, flash-blinks after the start button is pressed, and then emits a one-cycle `start_done` to the game FSM.

## Interface
Parameters:
- `X0`, 10'd265: left column of banner.
- `Y0`, 10'd300: top row of banner.
- `BLINK_FRAMES`, 30: frames per steady on/off half-period.
- `FLASH_FRAMES`, 4: frames per flash on/off half-period.
- `FLASH_COUNT`, 6: number of flash on-phases before done.

Ports:
- `Clk`, input, 1: pixel clock, the only clock.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `DrawX`, input, 10: current pixel column.
- `DrawY`, input, 10: current pixel row.
- `VS`, input, 1: VGA vsync, active low.
- `enable`, input, 1: title screen active.
- `start_btn`, input, 1: start key, level, already synchronised.
- `rom_addr`, output, 4: row address to the text ROM.
- `rom_data`, input, 110: ROM row, combinational from `rom_addr`.
- `pixel_on`, output, 1: banner pixel lit.
- `start_done`, output, 1: one-cycle pulse at the end of the flash sequence.

## Operation
- Frame tick: registered falling edge of `VS`. One-cycle `frame_tick`.
- Stage 1, registered:
  - `in_box = (DrawX − X0) < 110 && (DrawY − Y0) < 16`. Both subtractions are unsigned 10-bit, so coordinates left of or above the box wrap to large values and fail the compare.
  - `rom_addr = (DrawY − Y0)[3:0]`.
  - `col = (DrawX − X0)[6:0]`.
- Stage 2, registered: `pixel_on = in_box_q && visible && rom_data[109 − col]`. Bit 109 is the leftmost pixel.
- FSM states: HIDDEN, ON, OFF, FLASH_ON, FLASH_OFF, DONE. `visible` is 1 only in ON and FLASH_ON.
- `frame_cnt` is 6 bits and clears on every state change. `flash_cnt` is 3 bits.
- `enable` low has priority over every other transition and forces HIDDEN from any state.
- Transitions:
  - HIDDEN→ON when `enable` is high.
  - ON↔OFF when `frame_tick` arrives with `frame_cnt == BLINK_FRAMES−1`.
  - ON or OFF → FLASH_ON on the rising edge of `start_btn`. `flash_cnt` is set to 0 on this transition.
  - FLASH_ON→FLASH_OFF after FLASH_FRAMES ticks.
  - FLASH_OFF→FLASH_ON after FLASH_FRAMES ticks, with `flash_cnt` incremented.
  - FLASH_OFF→DONE when `flash_cnt == FLASH_COUNT−1` at the period end.
  - DONE→HIDDEN when `enable` goes low.
- `start_done` is a registered pulse, high exactly the cycle after entry into DONE.
- `start_btn` edges are ignored in HIDDEN, FLASH_*, and DONE.
- A button rising edge and a frame-period end in the same cycle: the button wins and the next state is FLASH_ON.

## Timing
- Coordinate to `pixel_on` latency is 2 clocks, matched by the colour mapper's delayed DrawX/DrawY.
- `rom_addr` is valid 1 clock after DrawX/DrawY.
- The ROM is combinational. Its output is sampled at the stage-2 edge.
- Reset values:
  - `pixel_on` 0, `rom_addr` 0, `start_done` 0.
  - state HIDDEN, all counters 0.
  - `VS` edge register 1, button edge register 0.
- Reset assertion mid-flash returns to HIDDEN immediately, with no `start_done`.
- `visible` changes only on `frame_tick` or a button edge. A mid-frame button press may change `visible` partway through a frame; this tearing is accepted.

## Structure
- Package `banner_pkg`:
  - state enum `banner_state_t`.
  - constants `BANNER_W = 110`, `BANNER_H = 16`.
- Sub-module `frame_edge`: the VS falling-edge detector. It is reused for the button edge.
- The ROM is instantiated by the parent, not inside this block.

## Test plan
- Reset, then `enable = 1`, then scan DrawX = 265 and DrawY = 302 with the ROM row-2 pattern: `pixel_on` is high exactly 2 clocks later for the leftmost bit (1). At DrawX = 271 (bit 103 = 0), `pixel_on` is 0.
- DrawX = 264 and DrawX = 375 (outside the box, just left and just right): `pixel_on` is 0. DrawY = 315 maps to `rom_addr = 15`. DrawY = 299 does not light any pixel (wraparound check).
- `enable = 1` for 60 frame ticks: state goes ON → OFF at tick 30 → ON at tick 60. `pixel_on` is never high during OFF.
- Button pressed in ON at tick 10: FLASH_ON, then 6 on/off pairs of 4 frames. `start_done` pulses one cycle, 48 ticks after the press.
- Button edge on the same cycle as the 30th tick: FLASH_ON is entered, not OFF.
- `Reset_n` low during FLASH_OFF: all outputs 0 asynchronously, state HIDDEN, and `start_done` never pulses.
